// File: rtl/pwl_act_arbiter.sv
// Packet-granular round-robin arbiter sharing one activation unit among NUM_REQ requesters.
// Tags every issued sample so results return with their owner ID and last-flag.
module pwl_act_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16,
   parameter int ACT_LAT = 1,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [NUM_REQ*DATA_W-1:0] req_x,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      act_valid_in,
   output logic [DATA_W-1:0]         act_x,
   input  logic                      act_valid_out,
   input  logic [DATA_W-1:0]         act_y,
   output logic                      resp_valid,
   output logic [ID_W-1:0]           resp_id,
   output logic                      resp_last,
   output logic [DATA_W-1:0]         resp_y,
   output logic                      busy,
   output logic                      err
);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                       state_r, state_s;
   logic [ID_W-1:0]              owner_r, owner_s;
   logic [ID_W-1:0]              rr_ptr_r, rr_ptr_s;
   logic [ID_W-1:0]              pick_s;
   logic                         any_s;
   logic                         xfer_s;
   logic                         xfer_last_s;
   int                           idx_s;
   logic [ID_W-1:0]              issue_id_r;
   logic                         issue_last_r;
   logic [ACT_LAT-1:0]           tag_v_r;
   logic [ACT_LAT-1:0]           tag_last_r;
   logic [ACT_LAT-1:0][ID_W-1:0] tag_id_r;

   // Round-robin pick: scanning downwards lets the lowest offset from rr_ptr win.
   always_comb begin
      pick_s = '0;
      any_s  = 1'b0;
      idx_s  = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_s  = int'(rr_ptr_r) + k;
         idx_s  = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
         pick_s = req_valid[idx_s] ? ID_W'(idx_s) : pick_s;
         any_s  = any_s | req_valid[idx_s];
      end
   end

   // Beat transfer qualification for the current owner.
   always_comb begin
      xfer_s      = (state_r == BURST) & req_valid[owner_r];
      xfer_last_s = xfer_s & req_last[owner_r];
   end

   // Grant decode depends on state and owner only, never on req_valid.
   always_comb begin
      req_ready = '0;
      if (state_r == BURST) begin
         req_ready[owner_r] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state logic for the IDLE/BURST packet FSM.
   always_comb begin
      state_s  = state_r;
      owner_s  = owner_r;
      rr_ptr_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               state_s = BURST;
               owner_s = pick_s;
            end else begin
               state_s = IDLE;
            end
         end
         BURST: begin
            if (xfer_last_s) begin
               state_s  = IDLE;
               rr_ptr_s = (owner_r == ID_W'(NUM_REQ - 1)) ? '0 : (owner_r + ID_W'(1));
            end else begin
               state_s = BURST;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state, owner and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         owner_r  <= '0;
         rr_ptr_r <= '0;
      end else begin
         state_r  <= state_s;
         owner_r  <= owner_s;
         rr_ptr_r <= rr_ptr_s;
      end
   end

   // Issue register toward the activation unit; id/last ride alongside for tagging.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_valid_in <= 1'b0;
         act_x        <= '0;
         issue_id_r   <= '0;
         issue_last_r <= 1'b0;
      end else if (xfer_s) begin
         act_valid_in <= 1'b1;
         act_x        <= req_x[owner_r*DATA_W +: DATA_W];
         issue_id_r   <= owner_r;
         issue_last_r <= req_last[owner_r];
      end else begin
         act_valid_in <= 1'b0;
      end
   end

   // Tag line captures the issue register, so its tail lines up with act_valid_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_r    <= '0;
         tag_last_r <= '0;
         tag_id_r   <= '0;
      end else begin
         for (int i = ACT_LAT - 1; i > 0; i--) begin
            tag_v_r[i]    <= tag_v_r[i-1];
            tag_last_r[i] <= tag_last_r[i-1];
            tag_id_r[i]   <= tag_id_r[i-1];
         end
         tag_v_r[0]    <= act_valid_in;
         tag_last_r[0] <= issue_last_r;
         tag_id_r[0]   <= issue_id_r;
      end
   end

   // Return path and sticky tag/valid mismatch flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_last  <= 1'b0;
         resp_y     <= '0;
         err        <= 1'b0;
      end else begin
         resp_valid <= act_valid_out;
         err        <= err | (act_valid_out != tag_v_r[ACT_LAT-1]);
         if (act_valid_out) begin
            resp_y    <= act_y;
            resp_id   <= tag_id_r[ACT_LAT-1];
            resp_last <= tag_last_r[ACT_LAT-1];
         end else begin
            resp_y    <= resp_y;
            resp_id   <= resp_id;
            resp_last <= resp_last;
         end
      end
   end

   assign busy = (state_r == BURST) | (|tag_v_r) | act_valid_in | resp_valid;

endmodule

// File: tb/tb_pwl_act_arbiter.sv
// Directed bench: cycle table against an ACT_LAT=1 stub, plus latency sweep and reset corner cases.
module tb_pwl_act_arbiter;

   typedef struct packed {
      logic        rst;
      logic        spur;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [63:0] x;
      logic [42:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [63:0] req_x;
   logic        spur;

   logic [3:0]  rdy1, rdy3, rdy5;
   logic        avi1, avi3, avi5;
   logic [15:0] ax1, ax3, ax5;
   logic        avo1, avo3, avo5;
   logic [15:0] ay1, ay3, ay5;
   logic        rv1, rv3, rv5;
   logic [1:0]  rid1, rid3, rid5;
   logic        rl1, rl3, rl5;
   logic [15:0] ry1, ry3, ry5;
   logic        bz1, bz3, bz5;
   logic        er1, er3, er5;

   int pass_cnt = 0;
   int total_cnt = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   pwl_act_arbiter #(.NUM_REQ(4), .DATA_W(16), .ACT_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_x(req_x),
      .req_ready(rdy1), .act_valid_in(avi1), .act_x(ax1), .act_valid_out(avo1), .act_y(ay1),
      .resp_valid(rv1), .resp_id(rid1), .resp_last(rl1), .resp_y(ry1), .busy(bz1), .err(er1));
   pwl_act_arbiter #(.NUM_REQ(4), .DATA_W(16), .ACT_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_x(req_x),
      .req_ready(rdy3), .act_valid_in(avi3), .act_x(ax3), .act_valid_out(avo3), .act_y(ay3),
      .resp_valid(rv3), .resp_id(rid3), .resp_last(rl3), .resp_y(ry3), .busy(bz3), .err(er3));
   pwl_act_arbiter #(.NUM_REQ(4), .DATA_W(16), .ACT_LAT(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_x(req_x),
      .req_ready(rdy5), .act_valid_in(avi5), .act_x(ax5), .act_valid_out(avo5), .act_y(ay5),
      .resp_valid(rv5), .resp_id(rid5), .resp_last(rl5), .resp_y(ry5), .busy(bz5), .err(er5));

   // Pass-through activation stubs; the ACT_LAT=1 one can inject a spurious valid.
   logic            s1_v;
   logic [15:0]     s1_y;
   logic [2:0]      s3_v;
   logic [2:0][15:0] s3_y;
   logic [4:0]      s5_v;
   logic [4:0][15:0] s5_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_y <= '0;
         s3_v <= '0;
         s3_y <= '0;
         s5_v <= '0;
         s5_y <= '0;
      end else begin
         s1_v <= avi1;
         s1_y <= ax1;
         s3_v <= {s3_v[1:0], avi3};
         s3_y <= {s3_y[1:0], ax3};
         s5_v <= {s5_v[3:0], avi5};
         s5_y <= {s5_y[3:0], ax5};
      end
   end

   assign avo1 = s1_v | spur;
   assign ay1  = s1_y;
   assign avo3 = s3_v[2];
   assign ay3  = s3_y[2];
   assign avo5 = s5_v[4];
   assign ay5  = s5_y[4];

   function automatic logic [42:0] obs(logic [3:0] r, logic a, logic [15:0] ax, logic rv,
                                       logic [1:0] id, logic rl, logic [15:0] ry, logic b, logic e);
      return {r, a, ax, rv, id, rl, ry, b, e};
   endfunction

   function automatic vec_t mk(logic rst, logic sp, logic [3:0] v, logic [3:0] l, logic [63:0] x,
                               logic [3:0] r, logic a, logic [15:0] ax, logic rv, logic [1:0] id,
                               logic rl, logic [15:0] ry, logic b, logic e);
      vec_t t;
      t.rst  = rst;
      t.spur = sp;
      t.v    = v;
      t.l    = l;
      t.x    = x;
      t.exp  = obs(r, a, ax, rv, id, rl, ry, b, e);
      return t;
   endfunction

   function automatic logic [63:0] x2(logic [15:0] s);
      return {16'h0000, s, 32'h0000_0000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic sweep_chk(input int lat, input int c, input logic rv, input logic [1:0] id,
                            input logic rl, input logic [15:0] y);
      logic [15:0] ys [3];
      int k;
      logic ev;
      ys[0] = 16'hF800;
      ys[1] = 16'h0000;
      ys[2] = 16'h07FF;
      k  = c - (lat + 3);
      ev = (k >= 0) && (k < 3);
      chk($sformatf("sweep_lat%0d_valid_c%0d", lat, c), {63'd0, rv}, {63'd0, ev});
      if (ev) begin
         chk($sformatf("sweep_lat%0d_data_c%0d", lat, c), {45'd0, id, rl, y},
             {45'd0, 2'd2, (k == 2), ys[k]});
      end
   endtask

   localparam logic [63:0] XF = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};

   initial begin
      logic [15:0] sx [4];
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      req_x     = 64'd0;
      spur      = 1'b0;
      repeat (2) @(negedge clk);

      // single requester 2: packet {-2048, 0, 2047}
      tbl.push_back(mk(1'b1,1'b0,4'b0100,4'b0000,x2(16'hF800), 4'b0000,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0100,4'b0000,x2(16'hF800), 4'b0100,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0100,4'b0000,x2(16'h0000), 4'b0100,1'b1,16'hF800,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0100,4'b0100,x2(16'h07FF), 4'b0100,1'b1,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,x2(16'h0000), 4'b0000,1'b1,16'h07FF,1'b1,2'd2,1'b0,16'hF800,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,x2(16'h0000), 4'b0000,1'b0,16'h07FF,1'b1,2'd2,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,x2(16'h0000), 4'b0000,1'b0,16'h07FF,1'b1,2'd2,1'b1,16'h07FF,1'b1,1'b0));
      tbl.push_back(mk(1'b0,1'b0,4'b0000,4'b0000,x2(16'h0000), 4'b0000,1'b0,16'h07FF,1'b0,2'd2,1'b1,16'h07FF,1'b0,1'b0));
      // fairness: all four requesters, 2-beat packets, order 0,1,2,3,0
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0000,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0001,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b1111,XF, 4'b0001,1'b1,16'h00A0,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0000,1'b1,16'h00A0,1'b0,2'd0,1'b0,16'h0000,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0010,1'b0,16'h00A0,1'b1,2'd0,1'b0,16'h00A0,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b1111,XF, 4'b0010,1'b1,16'h00A1,1'b1,2'd0,1'b1,16'h00A0,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0000,1'b1,16'h00A1,1'b0,2'd0,1'b1,16'h00A0,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0100,1'b0,16'h00A1,1'b1,2'd1,1'b0,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b1111,XF, 4'b0100,1'b1,16'h00A2,1'b1,2'd1,1'b1,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0000,1'b1,16'h00A2,1'b0,2'd1,1'b1,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b1000,1'b0,16'h00A2,1'b1,2'd2,1'b0,16'h00A2,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b1111,XF, 4'b1000,1'b1,16'h00A3,1'b1,2'd2,1'b1,16'h00A2,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b1111,4'b0000,XF, 4'b0000,1'b1,16'h00A3,1'b0,2'd2,1'b1,16'h00A2,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A3,1'b1,2'd3,1'b0,16'h00A3,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A3,1'b1,2'd3,1'b1,16'h00A3,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0001,4'b0001,XF, 4'b0001,1'b0,16'h00A3,1'b0,2'd3,1'b1,16'h00A3,1'b1,1'b0));
      // intra-packet gap on requester 1 while requester 0 waits
      tbl.push_back(mk(1'b1,1'b0,4'b0011,4'b0000,XF, 4'b0000,1'b1,16'h00A0,1'b0,2'd3,1'b1,16'h00A3,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0011,4'b0000,XF, 4'b0010,1'b0,16'h00A0,1'b0,2'd3,1'b1,16'h00A3,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0001,4'b0000,XF, 4'b0010,1'b1,16'h00A1,1'b1,2'd0,1'b1,16'h00A0,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0001,4'b0000,XF, 4'b0010,1'b0,16'h00A1,1'b0,2'd0,1'b1,16'h00A0,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0001,4'b0000,XF, 4'b0010,1'b0,16'h00A1,1'b1,2'd1,1'b0,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0011,4'b0010,XF, 4'b0010,1'b0,16'h00A1,1'b0,2'd1,1'b0,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0001,4'b0000,XF, 4'b0000,1'b1,16'h00A1,1'b0,2'd1,1'b0,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A1,1'b0,2'd1,1'b0,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A1,1'b1,2'd1,1'b1,16'h00A1,1'b1,1'b0));
      // spurious act_valid_out, sticky err until reset
      tbl.push_back(mk(1'b1,1'b1,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A1,1'b0,2'd1,1'b1,16'h00A1,1'b1,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A1,1'b1,2'd1,1'b1,16'h00A1,1'b1,1'b1));
      tbl.push_back(mk(1'b0,1'b0,4'b0000,4'b0000,XF, 4'b0001,1'b0,16'h00A1,1'b0,2'd1,1'b1,16'h00A1,1'b1,1'b1));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0000,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b0,1'b0));
      tbl.push_back(mk(1'b1,1'b0,4'b0000,4'b0000,XF, 4'b0000,1'b0,16'h0000,1'b0,2'd0,1'b0,16'h0000,1'b0,1'b0));

      foreach (tbl[n]) begin
         @(negedge clk);
         chk($sformatf("vec%0d", n), {21'd0, obs(rdy1, avi1, ax1, rv1, rid1, rl1, ry1, bz1, er1)},
             {21'd0, tbl[n].exp});
         rst_n     = tbl[n].rst;
         spur      = tbl[n].spur;
         req_valid = tbl[n].v;
         req_last  = tbl[n].l;
         req_x     = tbl[n].x;
      end

      // latency sweep: same packet through ACT_LAT = 1, 3, 5
      sx[0] = 16'hF800;
      sx[1] = 16'hF800;
      sx[2] = 16'h0000;
      sx[3] = 16'h07FF;
      @(negedge clk);
      rst_n     = 1'b0;
      spur      = 1'b0;
      req_valid = 4'b0000;
      req_last  = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         sweep_chk(1, c, rv1, rid1, rl1, ry1);
         sweep_chk(3, c, rv3, rid3, rl3, ry3);
         sweep_chk(5, c, rv5, rid5, rl5, ry5);
         req_valid = (c <= 3) ? 4'b0100 : 4'b0000;
         req_last  = (c == 3) ? 4'b0100 : 4'b0000;
         req_x     = x2(sx[(c <= 3) ? c : 3]);
         @(negedge clk);
      end
      chk("sweep_err", {61'd0, er1, er3, er5}, 64'd0);

      // reset in the middle of a packet with samples in flight
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b0001;
      req_last  = 4'b0000;
      req_x     = {48'd0, 16'h1234};
      @(negedge clk);
      req_x = {48'd0, 16'h5678};
      @(negedge clk);
      req_x = {48'd0, 16'h9ABC};
      @(negedge clk);
      chk("midpkt_busy_before", {62'd0, bz1, avi1}, {62'd0, 1'b1, 1'b1});
      rst_n = 1'b0;
      #1;
      chk("midpkt_reset_dut1", {21'd0, obs(rdy1, avi1, ax1, rv1, rid1, rl1, ry1, bz1, er1)}, 64'd0);
      chk("midpkt_reset_dut5", {21'd0, obs(rdy5, avi5, ax5, rv5, rid5, rl5, ry5, bz5, er5)}, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("post_reset_quiet_c%0d", c), {61'd0, er1, rv1, bz1}, 64'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pwl_act_arbiter.md
# pwl_act_arbiter

Round-robin, packet-granular arbiter that shares one piecewise-linear activation unit (e.g. `pwl_sigmoid_3`) among `NUM_REQ` requesters. Each requester streams a packet of signed fixed-point samples. The arbiter serialises the packets into the unit's `valid_in`/`x_in` port and tags every sample in flight. It then routes each result back with its requester ID and a last-flag. It sits between the generator/discriminator layer engines and the shared activation datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `DATA_W`, 16: sample width, signed; matches the activation unit.
- `ACT_LAT`, 1: activation unit latency, in cycles from `valid_in` to `valid_out`; must be ≥1.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: per-requester sample valid.
- `req_last`, in, NUM_REQ: per-requester last sample of packet.
- `req_x`, in, NUM_REQ*DATA_W: packed samples; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ready`, out, NUM_REQ: per-requester accept.
- `act_valid_in`, out, 1: valid to the activation unit.
- `act_x`, out, DATA_W: sample to the activation unit.
- `act_valid_out`, in, 1: valid from the activation unit.
- `act_y`, in, DATA_W: result from the activation unit.
- `resp_valid`, out, 1: result valid. There is no backpressure; the sink always accepts.
- `resp_id`, out, ID_W: owning requester.
- `resp_last`, out, 1: result is the last of its packet.
- `resp_y`, out, DATA_W: result.
- `busy`, out, 1: a packet is granted or any sample is in flight.
- `err`, out, 1: sticky tag/valid mismatch flag.

## Operation
- FSM with two states, IDLE and BURST. It resets to IDLE, with `rr_ptr`=0 and `owner`=0.
- IDLE:
  - If any `req_valid` is high, select the first asserted index scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - Register that index as `owner` and go to BURST.
  - No samples are accepted in IDLE, and `req_ready`=0.
- BURST:
  - `req_ready[owner]`=1 and all other bits are 0. `req_ready` is decoded from state and `owner` only, never from `req_valid`.
  - A beat transfers when `req_valid[owner] & req_ready[owner]`.
  - A beat with `req_last[owner]`=1 returns the FSM to IDLE and sets `rr_ptr` = (`owner`+1) mod `NUM_REQ`.
  - `req_valid` gaps inside a packet are legal. The grant is held and no timeout exists.
- Issue path, registered:
  - On a transfer: `act_valid_in`←1 and `act_x`←sample. Otherwise `act_valid_in`←0 and `act_x` holds its value.
- Tag line:
  - A shift register of `ACT_LAT` stages. Each stage holds {valid, id, last}.
  - Entry is loaded in the same cycle `act_valid_in` is driven, so the tail aligns with `act_valid_out`.
  - The line advances every cycle and never stalls.
- Return path, registered:
  - `resp_valid`←`act_valid_out`.
  - When `act_valid_out`=1: `resp_y`←`act_y`, and `resp_id`/`resp_last`←tail tag.
  - Otherwise those fields hold their values.
- Error check:
  - If `act_valid_out` ≠ tail.valid in any cycle, set `err` to 1.
  - `err` is cleared only by reset. The result is still forwarded with the tail tag fields.
- `busy` = (state==BURST) | OR of the tag-line valid bits | `act_valid_in` | `resp_valid`.
- No arithmetic is done on data; samples and results pass through bit-exact.

## Timing
- Reset values (async assert): `req_ready`=0, `act_valid_in`=0, `act_x`=0, tag line all-zero, `resp_valid`=0, `resp_id`=0, `resp_last`=0, `resp_y`=0, `err`=0, `busy`=0.
- Grant latency: `req_valid` seen in IDLE at cycle t gives `req_ready` at t+1. The first transfer can occur at t+1.
- Sample latency:
  - Transfer at t gives `act_valid_in` at t+1.
  - Then `act_valid_out` at t+1+`ACT_LAT`.
  - Then `resp_valid` at t+2+`ACT_LAT`. This is 3 cycles for `ACT_LAT`=1.
- Throughput: 1 sample/cycle within a packet.
- Packet boundaries: exactly one idle issue cycle between the last beat of one packet and the first beat of the next (the IDLE cycle).
- Single-beat packet (`req_last` on the first beat): BURST lasts 1 cycle.
- A requester whose `req_valid` drops while it is not owner loses nothing; it is rescanned at the next IDLE.
- Reset mid-packet or with samples in flight:
  - Everything clears and in-flight results are discarded.
  - A late `act_valid_out` after reset sets `err`; the bench must reset the activation unit together with the arbiter.

## Test plan
- Single requester: req 2 sends packet x={-2048, 0, 2047} (last on the third beat), with a pass-through stub unit (`ACT_LAT`=1).
  - Required: `resp_y`={-2048, 0, 2047}, `resp_id`=2, `resp_last` only on the third beat.
  - First `resp_valid` exactly 3 cycles after the first transfer.
- Round-robin fairness: all 4 requesters hold `req_valid`, each sending 2-beat packets.
  - Required: grant order 0,1,2,3,0…, with one IDLE cycle between packets.
  - Required: `rr_ptr`=1 after the first packet.
- Intra-packet gaps: req 1 deasserts `req_valid` for 3 cycles mid-packet while req 0 is pending.
  - Required: req 1 keeps the grant, and req 0 sees `req_ready`=0 until req 1's last beat.
- Latency sweep: repeat the single-requester test at `ACT_LAT`=1, 3, 5.
  - Required: `resp_valid` at transfer+`ACT_LAT`+2, IDs correct, `err`=0.
- Error injection: the stub asserts a spurious `act_valid_out` with nothing in flight.
  - Required: `err`=1 the next cycle and it stays 1 until `rst_n`=0.
- Real unit plus reset: connect `pwl_sigmoid_3` and stream the input CSV via req 0, comparing against the golden CSV. Then assert `rst_n`=0 mid-packet.
  - Required: all outputs at reset values in the same cycle, and `busy`=0.
